// File: rtl/mostra_sequencia_pkg.sv
// Shared state codes for the memory game. The debug display decoder and the
// jogada-checking control unit read the same codes, so they are kept here.
package mostra_sequencia_pkg;

    typedef enum logic [3:0] {
        inicial    = 4'h0,
        preparacao = 4'h1,
        carrega    = 4'h2,
        acende     = 4'h3,
        apaga      = 4'h4,
        proximo    = 4'h5,
        fim        = 4'hF
    } estado_t;

    localparam logic [3:0] DB_ILEGAL = 4'hE;

    // Debug code for a state register value; anything off the list shows E.
    function automatic logic [3:0] codigo_db(input estado_t e);
        case (e)
            inicial, preparacao, carrega, acende, apaga, proximo, fim:
                codigo_db = e;
            default:
                codigo_db = DB_ILEGAL;
        endcase
    endfunction

    // Phase timer width: one counter serves both the lit and blank phases.
    // A single-cycle phase still needs a 1-bit counter.
    function automatic int largura_timer(input int on_c, input int off_c);
        int maior;
        maior = (on_c > off_c) ? on_c : off_c;
        largura_timer = (maior > 1) ? $clog2(maior) : 1;
    endfunction

endpackage

// File: rtl/mostra_sequencia_contador_tempo.sv
// Phase timer: up-counter with synchronous clear (priority over enable) and a
// terminal-count flag against a runtime compare value.
module mostra_sequencia_contador_tempo #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpa,
    input  logic         conta,
    input  logic [W-1:0] fim_contagem,
    output logic         terminal
);

    logic [W-1:0] valor;

    // Count while enabled; clear wins so a terminal edge restarts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            valor <= '0;
        else if (limpa)
            valor <= '0;
        else if (conta)
            valor <= valor + 1'b1;
    end

    assign terminal = (valor == fim_contagem);

endmodule

// File: rtl/mostra_sequencia.sv
// Sequence presenter: walks ROM addresses 0..limite, lighting each entry for
// ON_CYCLES then blanking for OFF_CYCLES, and pulses pronto when finished.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  inicial    | idle, waiting for iniciar
//  preparacao | clear address, latch limite
//  carrega    | latch ROM data into the LED register
//  acende     | entry lit, timer runs to ON_CYCLES-1
//  apaga      | LEDs blank, timer runs to OFF_CYCLES-1, end check
//  proximo    | advance address
//  fim        | pronto pulse, back to inicial
module mostra_sequencia
    import mostra_sequencia_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int ADDR_W     = 4,
    parameter int ON_CYCLES  = 500,
    parameter int OFF_CYCLES = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    output logic [ADDR_W-1:0] mem_endereco,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [DATA_W-1:0] leds,
    output logic              mostrando,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam int TW = largura_timer(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0] ON_FIM  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_FIM = TW'(OFF_CYCLES - 1);

    estado_t           estado;
    logic [ADDR_W-1:0] limite_reg;
    logic              timer_limpa;
    logic              timer_conta;
    logic              timer_tc;
    logic [TW-1:0]     timer_fim;

    // Timer runs only in the two display phases; it is cleared on entry to
    // each phase and at its own terminal count.
    always_comb begin
        timer_conta = (estado == acende) || (estado == apaga);
        timer_limpa = (estado == preparacao) || (estado == carrega)
                      || (timer_conta && timer_tc);
        timer_fim   = (estado == acende) ? ON_FIM : OFF_FIM;
    end

    mostra_sequencia_contador_tempo #(
        .W (TW)
    ) u_timer (
        .clock        (clock),
        .reset        (reset),
        .limpa        (timer_limpa),
        .conta        (timer_conta),
        .fim_contagem (timer_fim),
        .terminal     (timer_tc)
    );

    // Control FSM with address counter, LED register and registered outputs.
    // The end check compares before incrementing, so the address never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= inicial;
            mem_endereco <= '0;
            limite_reg   <= '0;
            leds         <= '0;
            mostrando    <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            case (estado)
                inicial: begin
                    if (iniciar) begin
                        estado    <= preparacao;
                        mostrando <= 1'b1;
                    end
                end
                preparacao: begin
                    mem_endereco <= '0;
                    limite_reg   <= limite;
                    estado       <= carrega;
                end
                carrega: begin
                    leds   <= mem_dado;
                    estado <= acende;
                end
                acende: begin
                    if (timer_tc) begin
                        leds   <= '0;
                        estado <= apaga;
                    end
                end
                apaga: begin
                    if (timer_tc) begin
                        if (mem_endereco == limite_reg) begin
                            estado    <= fim;
                            mostrando <= 1'b0;
                            pronto    <= 1'b1;
                        end else begin
                            estado <= proximo;
                        end
                    end
                end
                proximo: begin
                    mem_endereco <= mem_endereco + 1'b1;
                    estado       <= carrega;
                end
                fim: begin
                    pronto <= 1'b0;
                    estado <= inicial;
                end
                default: begin
                    estado       <= inicial;
                    mem_endereco <= '0;
                    leds         <= '0;
                    mostrando    <= 1'b0;
                    pronto       <= 1'b0;
                end
            endcase
        end
    end

    assign db_estado = codigo_db(estado);

endmodule
